fifo_sync: RTL
==============

FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each stored word.
REQ-002 Parameter DEPTH, default 4: number of storage entries; power of two, minimum 2.
REQ-003 Parameter AF_THRESH, default 3: occupancy at or above which almost_full is asserted.
REQ-004 Parameter AE_THRESH, default 1: occupancy at or below which almost_empty is asserted.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_L  input  1  asynchronous, active-low reset.
REQ-007 push  input  1  write request; data_in is captured when the write is accepted.
REQ-008 data_in  input  DATA_WIDTH  write data.
REQ-009 pop  input  1  read request.
REQ-010 data_out  output  DATA_WIDTH  registered read data.
REQ-011 valid_out  output  1  data_out holds a newly popped word this cycle.
REQ-012 full  output  1  occupancy equals DEPTH.
REQ-013 empty  output  1  occupancy equals 0.
REQ-014 almost_full  output  1  occupancy is greater than or equal to AF_THRESH.
REQ-015 almost_empty  output  1  occupancy is less than or equal to AE_THRESH.
REQ-016 count  output  log2(DEPTH)+1  current occupancy, range 0 to DEPTH.
REQ-017 overflow  output  1  sticky flag: a push was rejected.
REQ-018 underflow  output  1  sticky flag: a pop was rejected.

Function
REQ-019 Storage: DEPTH x DATA_WIDTH register array; write and read pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 modulo DEPTH.
REQ-020 Write acceptance: a push is accepted when full=0, or when full=1 and pop=1 in the same cycle; an accepted push writes data_in at the write pointer and then increments the write pointer.
REQ-021 Read acceptance: a pop is accepted when empty=0; an accepted pop loads the word at the read pointer into data_out and increments the read pointer.
REQ-022 Read latency: data_out and valid_out update on the edge that samples the pop, so data is visible in the cycle after pop is asserted.
REQ-023 valid_out is 1 in the cycle after an accepted pop and 0 otherwise; data_out holds its last value when no pop is accepted.
REQ-024 count: increments by 1 on an accepted push with no accepted pop, decrements by 1 on an accepted pop with no accepted push, and is unchanged when both or neither are accepted.
REQ-025 Flags full, empty, almost_full and almost_empty are combinational decodes of the registered count only.
REQ-026 Push while full without pop: the write is dropped, storage and pointers are unchanged, and overflow is set to 1.
REQ-027 Pop while empty: the pop is ignored, valid_out=0, and underflow is set to 1; a simultaneous push is still accepted.
REQ-028 Push and pop while full: both are accepted and count stays at DEPTH.
REQ-029 overflow and underflow remain 1 until reset; no other event clears them.
REQ-030 Order: words are returned strictly in push order, with no loss or duplication while no overflow occurs.
REQ-031 The block contains only synthesizable RTL that maps onto NOT, NAND, NOR and positive-edge DFF cells.

Reset
REQ-032 reset_L=0 immediately and asynchronously forces: pointers=0, count=0, data_out=0, valid_out=0, overflow=0, underflow=0. The resulting flag values are empty=1, almost_empty=1, full=0 and almost_full=0.
REQ-033 Storage array contents are not reset and are don't-care after reset.
REQ-034 A reset asserted mid-operation discards all stored words; the first accepted pop after release returns the first word pushed after release.
REQ-035 Deassertion of reset_L is synchronous to clk; the first push is accepted on the first rising edge after release.

Verification
REQ-036 Reset then idle: expect count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0, valid_out=0.
REQ-037 Fill and drain: push 0x11, 0x22, 0x33, 0x44, then pop 4 times. During fill, almost_full rises at count=3 and full at count=4. During drain, data_out reads 0x11, 0x22, 0x33, 0x44, each with valid_out=1 one cycle after its pop. The drain ends with empty=1.
REQ-038 Overflow: while full, push 0x55 with pop=0. Expect count to stay at 4 and overflow=1. Subsequent pops return 0x11..0x44, with no 0x55.
REQ-039 Underflow: while empty, pop with push=1 and data_in=0xA5. Expect underflow=1, valid_out=0 and count=1; the next pop returns 0xA5.
REQ-040 Full simultaneous push and pop: with the FIFO holding 0x11..0x44, push 0x66 and pop in the same cycle. Expect data_out=0x11 and count=4; draining then returns 0x22, 0x33, 0x44, 0x66.
REQ-041 Wrap and mid-op reset: run 10 push/pop pairs so the pointers wrap twice and check the order. Then push 2 words, pulse reset_L low between clock edges, and confirm all outputs clear asynchronously and empty=1.

Source files
------------

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO built on a register array, with a registered read port.
//
// Ports
//   clk          rising-edge clock for all state changes
//   reset_L      asynchronous active-low reset
//   push         write request; data_in is stored when the write is accepted
//   data_in      write data
//   pop          read request
//   data_out     registered read data; holds its value when no pop is accepted
//   valid_out    data_out holds a word popped on the previous edge
//   full         occupancy == DEPTH
//   empty        occupancy == 0
//   almost_full  occupancy >= AF_THRESH
//   almost_empty occupancy <= AE_THRESH
//   count        current occupancy, 0..DEPTH
//   overflow     sticky: a push was rejected because the FIFO was full
//   underflow    sticky: a pop was rejected because the FIFO was empty
module fifo_sync #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AF_THRESH  = 3,
  parameter int unsigned AE_THRESH  = 1
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;
  logic [CW-1:0]         count_next;

  // Flags decode the registered occupancy only.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == CW'(0));
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  // A full FIFO still takes a push when a pop frees a slot on the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop);

  // Occupancy update: simultaneous accepted push and pop cancel out.
  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = count - CW'(1);
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, read register and sticky error flags.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_next;
      valid_out <= pop_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        // When full with push and pop, wr_ptr == rd_ptr: the old word is read
        // before the new one lands, since both use pre-edge array contents.
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PW'(1);
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      if (pop && !pop_ok) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
